// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding,
// BCD digit limit and the decade increment helper.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Next value of a decade digit: 0..9 then wrap to 0.
    // Out-of-range codes also fold back to 0 so a corrupted digit self-heals.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        logic [3:0] r;
        if (d >= BCD_MAX) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One synchronous decade stage of the stopwatch digit chain.
// sclr has priority over en; at_max flags the carry condition to the next stage.
module bcd_digit
    import stopwatch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       sclr,
    input  logic       en,
    output logic [3:0] q,
    output logic       at_max
);

    logic [3:0] q_r;

    // Digit register: async reset, synchronous clear, increment on enable.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r <= 4'd0;
        end else if (sclr) begin
            q_r <= 4'd0;
        end else if (en) begin
            q_r <= bcd_inc(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q      = q_r;
    assign at_max = (q_r == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear stopwatch controller.
// A prescaler divides clk down to a count tick while running; the tick
// drives a synchronous cascade of BCD decade digits. The display bus can be
// frozen on a lap value while the live count keeps advancing underneath.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 1000000,
    parameter int DIV_W      = 20,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    start_stop,
    input  logic                    lap,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    lap_active,
    output logic                    overflow,
    output logic                    tick
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);

    sw_state_e               state_r;
    sw_state_e               state_nxt;
    logic [DIV_W-1:0]        presc_r;
    logic [4*NUM_DIGITS-1:0] lap_r;
    logic                    lap_active_r;
    logic                    lap_active_nxt;
    logic                    overflow_r;
    logic                    enter_idle_s;
    logic                    lap_capture_s;
    logic                    tick_s;
    logic [NUM_DIGITS-1:0]   en_s;
    logic [NUM_DIGITS-1:0]   at_max_s;
    logic [4*NUM_DIGITS-1:0] live_s;
    logic                    all_max_s;

    // Count tick: last prescaler state while running.
    always_comb begin
        tick_s = 1'b0;
        if ((state_r == ST_RUN) && (presc_r == PRESC_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Next-state and control decode; priority clear > start_stop > lap.
    always_comb begin
        state_nxt      = state_r;
        lap_active_nxt = lap_active_r;
        enter_idle_s   = 1'b0;
        lap_capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_nxt    = ST_IDLE;
                    enter_idle_s = 1'b1;
                end else if (start_stop) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_nxt    = ST_IDLE;
                    enter_idle_s = 1'b1;
                end else if (start_stop) begin
                    state_nxt = ST_PAUSE;
                end else if (lap) begin
                    lap_capture_s  = 1'b1;
                    lap_active_nxt = ~lap_active_r;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_nxt    = ST_IDLE;
                    enter_idle_s = 1'b1;
                end else if (start_stop) begin
                    state_nxt = ST_RUN;
                end else if (lap) begin
                    lap_active_nxt = 1'b0;
                end else begin
                    state_nxt = ST_PAUSE;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                enter_idle_s = 1'b1;
            end
        endcase
        if (enter_idle_s) begin
            lap_active_nxt = 1'b0;
        end else begin
            lap_active_nxt = lap_active_nxt;
        end
    end

    // FSM state and lap flag registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r      <= ST_IDLE;
            lap_active_r <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            lap_active_r <= lap_active_nxt;
        end
    end

    // Prescaler: counts only in RUN, holds in PAUSE so resume continues the period.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc_r <= '0;
        end else if (enter_idle_s) begin
            presc_r <= '0;
        end else if (state_r == ST_RUN) begin
            if (tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRESC_ONE;
            end
        end else begin
            presc_r <= presc_r;
        end
    end

    // Lap register: captures the pre-increment live count.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lap_r <= '0;
        end else if (lap_capture_s) begin
            lap_r <= live_s;
        end else begin
            lap_r <= lap_r;
        end
    end

    // Sticky overflow: set on a tick with every digit at 9, cleared only on entering IDLE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            overflow_r <= 1'b0;
        end else if (enter_idle_s) begin
            overflow_r <= 1'b0;
        end else if (tick_s && all_max_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign all_max_s = &at_max_s;

    // Synchronous enable chain: a stage advances when the tick arrives and all lower stages are at 9.
    always_comb begin
        en_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == 0) begin
                en_s[k] = tick_s;
            end else begin
                en_s[k] = en_s[k-1] & at_max_s[k-1];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .clr_n  (clr_n),
                .sclr   (enter_idle_s),
                .en     (en_s[g]),
                .q      (live_s[4*g +: 4]),
                .at_max (at_max_s[g])
            );
        end
    endgenerate

    assign digits     = lap_active_r ? lap_r : live_s;
    assign running    = (state_r == ST_RUN);
    assign lap_active = lap_active_r;
    assign overflow   = overflow_r;
    assign tick       = tick_s;

endmodule
